// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : RISC-V load/store funct3 codes, responder FSM states, size decode
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_load_align
//  Purpose  : Extract the addressed lanes of a doubleword and sign/zero extend
//  Revision : 1.0 - initial release
// ============================================================================
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] w_shifted;

    assign w_shifted = dword >> {byte_off, 3'b000};

    always_comb begin
        data = 64'd0;
        case (funct3)
            LB:      data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            LH:      data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            LW:      data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            LD:      data = w_shifted;
            LBU:     data = {56'd0, w_shifted[7:0]};
            LHU:     data = {48'd0, w_shifted[15:0]};
            LWU:     data = {32'd0, w_shifted[31:0]};
            default: data = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Fixed-latency RISC-V data memory with request/response handshake
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY  = 2,
    parameter int DEPTH_DW = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_IDX_W = $clog2(DEPTH_DW);
    localparam logic [64:0] c_BYTES = 65'(DEPTH_DW * 8);
    localparam logic [3:0]  c_LAT   = 4'(LATENCY);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [63:0]         r_addr;
    logic [63:0]         r_wdata;
    logic [63:0]         r_mem [DEPTH_DW];

    logic [3:0]          w_size;
    logic                w_funct3_bad;
    logic                w_misaligned;
    logic                w_oob;
    logic                w_fault;
    logic [c_IDX_W-1:0]  w_idx;
    logic [7:0]          w_lanes;
    logic [7:0]          w_be;
    logic [63:0]         w_wshift;
    logic                w_enter_resp;
    logic                w_store;
    logic [63:0]         w_load_data;

    assign req_ready    = (r_state == IDLE);

    assign w_size       = size_bytes(r_funct3);
    assign w_funct3_bad = r_write ? !(r_funct3 inside {SB, SH, SW, SD})
                                  : (r_funct3 == 3'b111);
    assign w_misaligned = |(r_addr[2:0] & (w_size[2:0] - 3'd1));
    assign w_oob        = ({1'b0, r_addr} + {61'd0, w_size}) > c_BYTES;
    assign w_fault      = w_funct3_bad || w_misaligned || w_oob;
    assign w_idx        = r_addr[c_IDX_W+2:3];

    always_comb begin
        w_lanes = 8'h00;
        case (r_funct3[1:0])
            2'b00:   w_lanes = 8'h01;
            2'b01:   w_lanes = 8'h03;
            2'b10:   w_lanes = 8'h0F;
            default: w_lanes = 8'hFF;
        endcase
    end

    assign w_be         = w_lanes << r_addr[2:0];
    assign w_wshift     = r_wdata << {r_addr[2:0], 3'b000};
    // Counter runs down to zero, so a zero latency still spends one BUSY cycle
    // and the response always lands LATENCY+1 edges after acceptance.
    assign w_enter_resp = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_store      = w_enter_resp && r_write && !w_fault;

    mem_load_align u_load_align (
        .dword    (r_mem[w_idx]),
        .byte_off (r_addr[2:0]),
        .funct3   (r_funct3),
        .data     (w_load_data)
    );

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= 64'd0;
            r_wdata   <= 64'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= c_LAT;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_enter_resp) begin
                        r_state   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_fault;
                        rsp_rdata <= (!r_write && !w_fault) ? w_load_data : 64'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Random + directed checks of two responders (LATENCY 2 and 0)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [63:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    logic [7:0]  mm [2][256];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2), .DEPTH_DW(32)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.LATENCY(0), .DEPTH_DW(32)) u_dut_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Reference: byte-addressed 256-byte memory, updated on accepted good stores.
    function automatic void model(input int d, input logic wr, input logic [2:0] f3,
                                  input logic [63:0] a, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic e);
        int          sz = 1 << f3[1:0];
        logic [63:0] v  = 64'd0;
        e  = 1'b0;
        rd = 64'd0;
        if (wr ? f3[2] : (f3 == 3'b111)) e = 1'b1;
        if ((a % 64'(sz)) != 0)          e = 1'b1;
        if (a > 64'(256 - sz))           e = 1'b1;
        if (!e && wr) begin
            for (int i = 0; i < sz; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
        end
        if (!e && !wr) begin
            for (int i = 0; i < sz; i++) v = v | (64'(mm[d][int'(a) + i]) << (8*i));
            if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
            rd = v;
        end
    endfunction

    task automatic access(input int d, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, input int hold,
                          output logic [63:0] got_d, output logic got_e);
        logic [63:0] exp_d;
        logic        exp_e;
        int          n = 0;
        model(d, wr, f3, a, wd, exp_d, exp_e);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3;
        req_addr[d]  = a;    req_wdata[d] = wd; rsp_ready[d]  = 1'b0;
        check_val("req_ready_idle", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        check_val("req_ready_busy", 64'(req_ready[d]), 64'd0);
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_val("latency", 64'(n), 64'(lat_of(d) + 1));
        got_d = rsp_rdata[d];
        got_e = rsp_err[d];
        check_val("rsp_rdata", got_d, exp_d);
        check_val("rsp_err", 64'(got_e), 64'(exp_e));
        for (int h = 0; h < hold; h++) begin
            // A stray store during RESP must be ignored entirely.
            req_valid[d] = 1'b1; req_write[d] = 1'b1; req_funct3[d] = 3'b011;
            req_addr[d]  = 64'd0; req_wdata[d] = 64'hDEAD_BEEF_DEAD_BEEF;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", 64'(rsp_valid[d]), 64'd1);
            check_val("hold_rdata", rsp_rdata[d], exp_d);
            check_val("hold_ready", 64'(req_ready[d]), 64'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check_val("post_valid", 64'(rsp_valid[d]), 64'd0);
        check_val("post_rdata", rsp_rdata[d], 64'd0);
        check_val("post_err", 64'(rsp_err[d]), 64'd0);
        check_val("post_ready", 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b0;
    endtask

    initial begin
        logic [63:0] gd;
        logic        ge;
        logic [63:0] a;
        logic [2:0]  f3;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d]  = 64'd0; req_wdata[d] = 64'd0; rsp_ready[d] = 1'b0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check_val("reset_valid", 64'(rsp_valid[d]), 64'd0);
            check_val("reset_rdata", rsp_rdata[d], 64'd0);
            check_val("reset_err", 64'(rsp_err[d]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                access(d, 1'b1, 3'b011, 64'(i * 8), {$urandom, $urandom}, 0, gd, ge);
            end
            // Doubleword store and load back
            access(d, 1'b1, 3'b011, 64'h10, 64'h1122334455667788, 0, gd, ge);
            access(d, 1'b0, 3'b011, 64'h10, 64'd0, 0, gd, ge);
            check_val("s1_ld", gd, 64'h1122334455667788);
            // Byte store, signed/unsigned byte loads, lane preservation
            access(d, 1'b1, 3'b000, 64'h13, 64'h80, 0, gd, ge);
            access(d, 1'b0, 3'b000, 64'h13, 64'd0, 0, gd, ge);
            check_val("s2_lb", gd, 64'hFFFFFFFFFFFFFF80);
            access(d, 1'b0, 3'b100, 64'h13, 64'd0, 0, gd, ge);
            check_val("s2_lbu", gd, 64'h80);
            access(d, 1'b0, 3'b011, 64'h10, 64'd0, 0, gd, ge);
            check_val("s2_ld", gd, 64'h1122334480667788);
            // Faults: misaligned load, out-of-range store
            access(d, 1'b0, 3'b010, 64'h12, 64'd0, 0, gd, ge);
            check_val("s3_lw_err", 64'(ge), 64'd1);
            access(d, 1'b1, 3'b011, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 0, gd, ge);
            check_val("s3_sd_err", 64'(ge), 64'd1);
            access(d, 1'b0, 3'b011, 64'h10, 64'd0, 0, gd, ge);
            check_val("s3_readback", gd, 64'h1122334480667788);
            access(d, 1'b0, 3'b011, 64'hF8, 64'd0, 0, gd, ge);
            // Backpressure for five cycles
            access(d, 1'b0, 3'b011, 64'h10, 64'd0, 5, gd, ge);
            access(d, 1'b0, 3'b011, 64'h00, 64'd0, 0, gd, ge);
            // Signed halfword
            access(d, 1'b1, 3'b001, 64'h16, 64'h8001, 0, gd, ge);
            access(d, 1'b0, 3'b001, 64'h16, 64'd0, 0, gd, ge);
            check_val("s6_lh", gd, 64'hFFFFFFFFFFFF8001);

            if (d == 0) begin
                // Reset while a store is still counting down must drop the store
                @(negedge clk);
                req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b011;
                req_addr[0]  = 64'h18; req_wdata[0] = 64'hA5A5_5A5A_0F0F_F0F0;
                @(posedge clk);
                @(negedge clk);
                req_valid[0] = 1'b0;
                @(posedge clk);
                #2 reset = 1'b0;
                #1;
                check_val("s5_valid", 64'(rsp_valid[0]), 64'd0);
                check_val("s5_rdata", rsp_rdata[0], 64'd0);
                @(negedge clk);
                reset = 1'b1;
                check_val("s5_ready", 64'(req_ready[0]), 64'd1);
                access(0, 1'b0, 3'b011, 64'h18, 64'd0, 0, gd, ge);
            end

            for (int i = 0; i < 150; i++) begin
                f3 = 3'($urandom_range(0, 7));
                a  = 64'($urandom_range(0, 271));
                if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
                if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
                access(d, 1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom},
                       $urandom_range(0, 2), gd, ge);
            end
            for (int i = 0; i < 32; i++) begin
                access(d, 1'b0, 3'b011, 64'(i * 8), 64'd0, 0, gd, ge);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
